// File: rtl/fabric_pkg.sv
// Shared types for the redundant fabric blocks: packet layouts, the redundant copy
// struct used on both the request and response sides, and the fault monitor state.
package fabric_pkg;

    localparam int RFAB_NCLS     = 4;
    localparam int RFAB_NSLC     = 4;
    localparam int RFAB_HDR_W    = 8;
    localparam int RFAB_PAY_W    = 16;
    localparam int RFAB_ERRCNT_W = 16;

    typedef enum logic [1:0] {
        OK,
        SUSPECT,
        FAILED
    } rfab_redund_mon_state_t;

    typedef struct packed {
        logic [RFAB_HDR_W-1:0] hdr;
        logic [RFAB_PAY_W-1:0] payload;
    } rfab_packet_t;

    typedef rfab_packet_t [RFAB_NSLC-1:0] rfab_packet_cls_t;
    typedef rfab_packet_cls_t [RFAB_NCLS-1:0] rfab_packet_blk_t;

    typedef struct packed {
        logic [RFAB_PAY_W-1:0] payload1;
        logic [RFAB_PAY_W-1:0] payload2;
        logic [RFAB_HDR_W-1:0] hdr1;
        logic [RFAB_HDR_W-1:0] hdr2;
    } rfab_redund_rsp_t;

    typedef rfab_redund_rsp_t [RFAB_NSLC-1:0] rfab_redund_cls_t;
    typedef rfab_redund_cls_t [RFAB_NCLS-1:0] rfab_redund_blk_t;

    typedef struct packed {
        logic faulty_hdr;
        logic faulty_payload;
    } rfab_redund_sel_t;

endpackage

// File: rtl/fabric_mux.sv
// Fabric switch: class lane c of the output is driven from class lane (c + sel) mod NCLS
// of the input, delayed by LATENCY register stages.
module fabric_mux
    import fabric_pkg::*;
#(
    parameter int NBL      = 4,
    parameter int NCLS     = RFAB_NCLS,
    parameter int LATENCY  = 2,
    parameter bit NO_RESET = 1'b0,
    parameter int PW       = $clog2(NBL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PW-1:0]    sel,
    input  rfab_redund_blk_t din,
    output rfab_redund_blk_t dout
);

    localparam int CIW = (NCLS > 1) ? $clog2(NCLS) : 1;

    rfab_redund_blk_t rotated;
    rfab_redund_blk_t pipe [LATENCY];

    always_comb begin
        rotated = din;
        for (int c = 0; c < NCLS; c++) begin
            rotated[c] = din[CIW'((c + int'(sel)) % NCLS)];
        end
    end

    if (NO_RESET) begin : g_no_rst
        // NOTE: datapath flops carry no reset; lanes are trusted via the copy compare, not reset.
        always_ff @(posedge clk) begin
            pipe[0] <= rotated;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end else begin : g_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe <= '{default: '0};
            end else begin
                pipe[0] <= rotated;
                for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[LATENCY-1];

endmodule

// File: rtl/fabric_redund_mon.sv
// Per-field fault monitor: THRESH consecutive mismatch cycles declare the field faulty
// (sticky until clr), plus a saturating count of all mismatch cycles.
module fabric_redund_mon
    import fabric_pkg::*;
#(
    parameter int THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mismatch,
    input  logic                     clr,
    output logic                     faulty,
    output logic                     fail_pulse,
    output logic [RFAB_ERRCNT_W-1:0] err_cnt
);

    localparam logic [3:0] THRESH_C = 4'(THRESH);

    rfab_redund_mon_state_t   state, state_nxt;
    logic [3:0]               run_cnt, run_cnt_nxt;
    logic [RFAB_ERRCNT_W-1:0] err_cnt_nxt;
    logic                     fail_pulse_nxt;

    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OK;
            run_cnt    <= '0;
            err_cnt    <= '0;
            fail_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            run_cnt    <= run_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
            fail_pulse <= fail_pulse_nxt;
        end
    end

    // NOTE: defaults first so no path through the case can leave a latch behind.
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        if (clr) begin
            state_nxt   = OK;
            run_cnt_nxt = '0;
        end else begin
            unique case (state)
                OK: begin
                    if (mismatch) begin
                        run_cnt_nxt = 4'd1;
                        state_nxt   = (THRESH_C == 4'd1) ? FAILED : SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (mismatch) begin
                        run_cnt_nxt = run_cnt + 4'd1;
                        if (run_cnt_nxt == THRESH_C) state_nxt = FAILED;
                    end else begin
                        state_nxt   = OK;
                        run_cnt_nxt = '0;
                    end
                end
                FAILED: state_nxt = FAILED;
                default: begin
                    state_nxt   = OK;
                    run_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        faulty         = (state == FAILED);
        fail_pulse_nxt = (state_nxt == FAILED) && (state != FAILED);
        err_cnt_nxt    = err_cnt;
        if (clr) begin
            err_cnt_nxt = '0;
        end else if (mismatch && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fabric_block_rsp.sv
// Response-direction redundant fabric block: duplicates each response, switches both
// copies, compares them at the output and forwards the copy the monitors trust.
module fabric_block_rsp
    import fabric_pkg::*;
#(
    parameter int NBL     = 4,
    parameter int NCLS    = RFAB_NCLS,
    parameter int NSLC    = RFAB_NSLC,
    parameter int LATENCY = 2,
    parameter int THRESH  = 4,
    parameter int PW      = $clog2(NBL)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PW-1:0]            sel,
    input  rfab_packet_blk_t         pkt_in_blk,
    input  logic                     inj_hdr,
    input  logic                     inj_payload,
    input  logic                     clr_fault,
    output rfab_packet_blk_t         pkt_out_blk,
    output rfab_redund_sel_t         rsel_out,
    output logic                     fault_irq,
    output logic [RFAB_ERRCNT_W-1:0] hdr_err_cnt,
    output logic [RFAB_ERRCNT_W-1:0] pay_err_cnt
);

    rfab_redund_blk_t red_in, red_out;
    logic mis_hdr, mis_pay;
    logic faulty_hdr, faulty_pay;
    logic hdr_pulse, pay_pulse;

    // Copy 2 optionally has bit 0 inverted so the whole redundancy path can be exercised.
    always_comb begin
        red_in = '0;
        for (int c = 0; c < NCLS; c++) begin
            for (int s = 0; s < NSLC; s++) begin
                red_in[c][s].hdr1     = pkt_in_blk[c][s].hdr;
                red_in[c][s].hdr2     = pkt_in_blk[c][s].hdr ^ RFAB_HDR_W'(inj_hdr);
                red_in[c][s].payload1 = pkt_in_blk[c][s].payload;
                red_in[c][s].payload2 = pkt_in_blk[c][s].payload ^ RFAB_PAY_W'(inj_payload);
            end
        end
    end

    fabric_mux #(
        .NBL     (NBL),
        .NCLS    (NCLS),
        .LATENCY (LATENCY),
        .NO_RESET(1'b1),
        .PW      (PW)
    ) u_fabric_mux (
        .clk  (clk),
        .rst_n(1'b1),
        .sel  (sel),
        .din  (red_in),
        .dout (red_out)
    );

    always_comb begin
        mis_hdr     = 1'b0;
        mis_pay     = 1'b0;
        pkt_out_blk = '0;
        for (int c = 0; c < NCLS; c++) begin
            for (int s = 0; s < NSLC; s++) begin
                mis_hdr = mis_hdr | (red_out[c][s].hdr1 != red_out[c][s].hdr2);
                mis_pay = mis_pay | (red_out[c][s].payload1 != red_out[c][s].payload2);
                pkt_out_blk[c][s].hdr     = rsel_out.faulty_hdr ? red_out[c][s].hdr2
                                                                : red_out[c][s].hdr1;
                pkt_out_blk[c][s].payload = rsel_out.faulty_payload ? red_out[c][s].payload2
                                                                    : red_out[c][s].payload1;
            end
        end
    end

    fabric_redund_mon #(.THRESH(THRESH)) u_mon_hdr (
        .clk       (clk),
        .rst_n     (rst_n),
        .mismatch  (mis_hdr),
        .clr       (clr_fault),
        .faulty    (faulty_hdr),
        .fail_pulse(hdr_pulse),
        .err_cnt   (hdr_err_cnt)
    );

    fabric_redund_mon #(.THRESH(THRESH)) u_mon_pay (
        .clk       (clk),
        .rst_n     (rst_n),
        .mismatch  (mis_pay),
        .clr       (clr_fault),
        .faulty    (faulty_pay),
        .fail_pulse(pay_pulse),
        .err_cnt   (pay_err_cnt)
    );

    assign rsel_out  = '{faulty_hdr: faulty_hdr, faulty_payload: faulty_pay};
    assign fault_irq = hdr_pulse | pay_pulse;

endmodule

// File: tb/tb_fabric_block_rsp.sv
// Randomized self-checking bench for fabric_block_rsp against a cycle-level model built
// from input history and per-field run/err counters.
module tb_fabric_block_rsp;
    import fabric_pkg::*;

    localparam int NBL     = 4;
    localparam int NCLS    = RFAB_NCLS;
    localparam int NSLC    = RFAB_NSLC;
    localparam int LATENCY = 2;
    localparam int THRESH  = 4;
    localparam int PW      = $clog2(NBL);
    localparam int PKT_W   = $bits(rfab_packet_blk_t);
    localparam int ERR_MAX = (1 << RFAB_ERRCNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [PW-1:0]            sel;
    rfab_packet_blk_t         pkt_in_blk;
    logic                     inj_hdr, inj_payload, clr_fault;
    rfab_packet_blk_t         pkt_out_blk;
    rfab_redund_sel_t         rsel_out;
    logic                     fault_irq;
    logic [RFAB_ERRCNT_W-1:0] hdr_err_cnt, pay_err_cnt;

    always #5 clk = ~clk;

    fabric_block_rsp #(
        .NBL(NBL), .NCLS(NCLS), .NSLC(NSLC), .LATENCY(LATENCY), .THRESH(THRESH), .PW(PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .pkt_in_blk (pkt_in_blk),
        .inj_hdr    (inj_hdr),
        .inj_payload(inj_payload),
        .clr_fault  (clr_fault),
        .pkt_out_blk(pkt_out_blk),
        .rsel_out   (rsel_out),
        .fault_irq  (fault_irq),
        .hdr_err_cnt(hdr_err_cnt),
        .pay_err_cnt(pay_err_cnt)
    );

    typedef struct {
        rfab_packet_blk_t pkt;
        logic [PW-1:0]    sel;
        bit               ih;
        bit               ip;
        bit               cl;
    } hist_t;

    typedef struct {
        int run;
        bit failed;
        int err;
    } mon_t;

    hist_t hist[$];
    mon_t  m_hdr, m_pay;
    bit    exp_irq;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    irq_seen = 0;

    task automatic check(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mon_t mon_reset();
        mon_t m;
        m.run = 0;
        m.failed = 1'b0;
        m.err = 0;
        return m;
    endfunction

    // One clock of a field monitor: run counts consecutive mismatches, err counts all of them.
    function automatic mon_t mon_next(input mon_t m, input bit mis, input bit clr, output bit pulse);
        mon_t r = m;
        pulse = 1'b0;
        if (clr) begin
            r = mon_reset();
        end else if (mis) begin
            if (r.err < ERR_MAX) r.err++;
            if (!r.failed) begin
                r.run++;
                if (r.run >= THRESH) begin
                    r.failed = 1'b1;
                    pulse = 1'b1;
                end
            end
        end else if (!r.failed) begin
            r.run = 0;
        end
        return r;
    endfunction

    function automatic rfab_packet_blk_t expect_out(input hist_t e, input bit fh, input bit fp);
        rfab_packet_blk_t r;
        for (int c = 0; c < NCLS; c++) begin
            for (int s = 0; s < NSLC; s++) begin
                r[c][s] = e.pkt[(c + int'(e.sel)) % NCLS][s];
                if (fh && e.ih) r[c][s].hdr[0] = ~r[c][s].hdr[0];
                if (fp && e.ip) r[c][s].payload[0] = ~r[c][s].payload[0];
            end
        end
        return r;
    endfunction

    task automatic step(input bit ih, input bit ip, input bit cl);
        bit ph, pp;
        hist_t e;
        logic [PKT_W-1:0] v;
        @(posedge clk);
        ph = 1'b0;
        pp = 1'b0;
        if (!rst_n) begin
            m_hdr = mon_reset();
            m_pay = mon_reset();
        end else if (hist.size() >= 3) begin
            // mux output seen in the previous cycle was driven three cycles ago
            m_hdr = mon_next(m_hdr, hist[$-2].ih, hist[$].cl, ph);
            m_pay = mon_next(m_pay, hist[$-2].ip, hist[$].cl, pp);
        end
        exp_irq = ph | pp;
        #1;
        for (int i = 0; i < PKT_W / 32; i++) v[i*32 +: 32] = $urandom();
        pkt_in_blk  = v;
        sel         = PW'($urandom_range(NBL - 1, 0));
        inj_hdr     = ih;
        inj_payload = ip;
        clr_fault   = cl;
        e.pkt = pkt_in_blk;
        e.sel = sel;
        e.ih  = ih;
        e.ip  = ip;
        e.cl  = cl;
        hist.push_back(e);
        if (hist.size() > 4) void'(hist.pop_front());
        @(negedge clk);
        if (hist.size() >= 3)
            check("pkt_out", pkt_out_blk, expect_out(hist[$-2], m_hdr.failed, m_pay.failed));
        check("rsel_out", PKT_W'({rsel_out.faulty_hdr, rsel_out.faulty_payload}),
              PKT_W'({m_hdr.failed, m_pay.failed}));
        check("fault_irq", PKT_W'(fault_irq), PKT_W'(exp_irq));
        check("hdr_err_cnt", PKT_W'(hdr_err_cnt), PKT_W'(m_hdr.err));
        check("pay_err_cnt", PKT_W'(pay_err_cnt), PKT_W'(m_pay.err));
        if (fault_irq) irq_seen++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        sel         = '0;
        pkt_in_blk  = '0;
        inj_hdr     = 1'b0;
        inj_payload = 1'b0;
        clr_fault   = 1'b0;
        m_hdr       = mon_reset();
        m_pay       = mon_reset();

        // Fill the unreset fabric pipeline while held in reset.
        repeat (4) step(0, 0, 0);
        rst_n = 1'b1;

        repeat (1000) step(0, 0, 0);
        check("clean_irq_none", PKT_W'(irq_seen), PKT_W'(0));

        irq_seen = 0;
        repeat (3) step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        check("hdr_cnt_3", PKT_W'(hdr_err_cnt), PKT_W'(3));
        check("hdr_not_faulty", PKT_W'(rsel_out.faulty_hdr), PKT_W'(0));
        check("hdr_irq_none", PKT_W'(irq_seen), PKT_W'(0));

        irq_seen = 0;
        repeat (4) step(0, 1, 0);
        repeat (8) step(0, 0, 0);
        check("pay_irq_once", PKT_W'(irq_seen), PKT_W'(1));
        check("pay_faulty_sticky", PKT_W'(rsel_out.faulty_payload), PKT_W'(1));
        check("pay_cnt_4", PKT_W'(pay_err_cnt), PKT_W'(4));

        step(0, 0, 1);
        step(0, 0, 0);
        check("clr_counts", PKT_W'({hdr_err_cnt, pay_err_cnt}), PKT_W'(0));

        irq_seen = 0;
        repeat (4) step(1, 1, 0);
        repeat (8) step(0, 0, 0);
        check("both_irq_once", PKT_W'(irq_seen), PKT_W'(1));
        check("both_faulty", PKT_W'({rsel_out.faulty_hdr, rsel_out.faulty_payload}), PKT_W'(2'b11));

        step(0, 0, 1);
        repeat (8) step(0, 1, 0);
        check("pay_failed_pre_clr", PKT_W'(rsel_out.faulty_payload), PKT_W'(1));
        step(0, 1, 1);
        step(0, 1, 0);
        check("clr_wins_cnt", PKT_W'(pay_err_cnt), PKT_W'(0));
        check("clr_wins_state", PKT_W'(rsel_out.faulty_payload), PKT_W'(0));
        repeat (6) step(0, 1, 0);
        check("pay_refail", PKT_W'(rsel_out.faulty_payload), PKT_W'(1));

        repeat (70000) step(0, 1, 0);
        check("pay_cnt_sat", PKT_W'(pay_err_cnt), PKT_W'(16'hFFFF));

        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rsel", PKT_W'({rsel_out.faulty_hdr, rsel_out.faulty_payload}), PKT_W'(0));
        check("async_rst_irq", PKT_W'(fault_irq), PKT_W'(0));
        check("async_rst_cnts", PKT_W'({hdr_err_cnt, pay_err_cnt}), PKT_W'(0));
        repeat (3) step(0, 0, 0);
        rst_n = 1'b1;
        repeat (20) step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fabric_block_rsp.md
Name: fabric_block_rsp

Overview:
Response-direction redundant fabric block. It carries responses from the slices back to the classes.
- Replicates each response header and payload into two copies.
- Switches both copies through fabric_mux.
- Compares the copies at the output and selects one copy.
- Runs a per-field fault monitor that decides which copy is trusted. It publishes that decision as rsel_out for the request-side redundant block and for CSR status.
- Sits between the slice response ports and the class response ports of each fabric block.

Parameters:
- NBL, 4, number of fabric blocks; sets the sel width.
- NCLS, 4, classes per block.
- NSLC, 4, slices per class.
- LATENCY, 2, fabric_mux pipeline depth in cycles.
- THRESH, 4, consecutive mismatch cycles needed to declare a field faulty (legal range 1..15).
- PW, Clog2(NBL), width of sel.

Ports:
- clk  input  1  fabric clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  PW  fabric_mux select, passed straight through.
- pkt_in_blk  input  rfab_packet_blk_t  slice-side responses (hdr and payload per cls/slc).
- inj_hdr  input  1  fault injection: invert bit 0 of hdr copy 2 on every lane, pre-mux.
- inj_payload  input  1  fault injection: invert bit 0 of payload copy 2 on every lane, pre-mux.
- clr_fault  input  1  single-cycle pulse; returns both monitors to OK and clears the error counters.
- pkt_out_blk  output  rfab_packet_blk_t  class-side responses.
- rsel_out  output  rfab_redund_sel_t  registered faulty_hdr / faulty_payload decision.
- fault_irq  output  1  one-cycle pulse when either monitor enters FAILED.
- hdr_err_cnt  output  RFAB_ERRCNT_W  saturating count of header-mismatch cycles.
- pay_err_cnt  output  RFAB_ERRCNT_W  saturating count of payload-mismatch cycles.

Behaviour:
Datapath
- The fabric is never reset: fabric_mux runs with NO_RESET, and its rst_n is tied TRUE.
- pkt_out_blk is therefore X until LATENCY cycles after the first valid input.
- The pkt_in_blk to pkt_out_blk latency is exactly LATENCY cycles.
- Output copy select per field: copy 2 when the matching rsel_out bit is 1, otherwise copy 1. The select is combinational from the registered rsel_out.

Compare
- mis_hdr = OR over all cls/slc of (hdr1 != hdr2) at the mux output, evaluated every cycle. mis_pay is the same for payload.
- Lanes carry no valid bit; idle lanes compare equal.

Monitor FSM (one per field; states OK, SUSPECT, FAILED; 4-bit run counter)
- OK:
  - mismatch: go to SUSPECT, cnt=1.
  - mismatch with THRESH==1: go straight to FAILED.
- SUSPECT:
  - mismatch: cnt+1; when cnt+1==THRESH, go to FAILED.
  - clean cycle: go to OK, cnt=0.
- FAILED: sticky. Exits only on reset or clr_fault.
  - rsel_out bit = 1 in FAILED, 0 otherwise.
  - The output switches to copy 2 on the first cycle after the THRESH-th consecutive mismatch cycle.
- fault_irq is registered. It is 1 for exactly one cycle, on the cycle the state becomes FAILED. If both fields fail in the same cycle, it is still a single pulse.

Error counters
- Increment on every mismatch cycle in any state, including FAILED.
- Saturate at all-ones; no wrap.

Boundary rules
- clr_fault coinciding with a mismatch: clr_fault wins. State goes to OK, cnt=0, error counter=0, and the mismatch is dropped.
- Reset mid-operation: all state is lost and the fabric pipeline is not flushed. Outputs are valid again after LATENCY cycles of valid input.
- Reset values: rsel_out=0, fault_irq=0, both err_cnt=0, both FSMs in OK, run counters=0.

Decomposition:
- The following go in fabric_pkg:
  - rfab_redund_mon_state_t, enum {OK, SUSPECT, FAILED}.
  - RFAB_ERRCNT_W = 16.
  - The redundant response struct (payload1, payload2, hdr1, hdr2) and its cls/blk array typedefs, shared with the request side.
- Sub-module fabric_redund_mon:
  - Inputs: clk, rst_n, mismatch, clr, THRESH.
  - Outputs: faulty, fail_pulse, err_cnt.
  - Instantiated twice (hdr, payload).
- The top level holds the replicate/inject logic, the fabric_mux instance, the compare trees and the output selects.

Test Plan:
- Reset, LATENCY=2, sel=1, random traffic with no injection for 1000 cycles → pkt_out_blk equals pkt_in_blk delayed 2 cycles and switched per sel; rsel_out=0; both err_cnt=0; fault_irq never pulses.
- inj_hdr=1 for 3 cycles, then 0 (THRESH=4) → hdr_err_cnt=3; hdr FSM OK→SUSPECT→OK; rsel_out.faulty_hdr stays 0; no irq.
- inj_payload=1 for 4 cycles → fault_irq pulses once on the cycle after the 4th mismatch cycle at the mux output; faulty_payload=1 stays set after injection stops; payload output taken from copy 2 (which carries the inverted bit 0) while injection is active, then matches the input again once injection stops.
- inj_hdr and inj_payload both held 4 cycles → single fault_irq pulse; rsel_out=faulty_hdr=1, faulty_payload=1.
- FAILED state with inj_payload still active, pulse clr_fault → pay_err_cnt=0 and FSM OK in the same cycle; FSM re-enters FAILED after 4 further cycles.
- inj_payload held 70000 cycles → pay_err_cnt saturates at 16'hFFFF; assert rst_n low mid-traffic → all outputs at reset values asynchronously.
